// File: rtl/cfg_ctrl_pkg.sv
// cfg_ctrl_pkg
// Shared definitions for the configuration chain loader.
//   cfg_state_t : loader FSM states (IDLE, SHIFT, VERIFY, DONE)
//   STATE_W     : width of the state encoding
//   cnt_width() : shift counter width able to hold the value chain_len
package cfg_ctrl_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        VERIFY = 2'd2,
        DONE   = 2'd3
    } cfg_state_t;

    // The counter is loaded with the chain length itself, so it needs
    // room for chain_len rather than chain_len-1.
    function automatic int cnt_width(input int chain_len);
        return $clog2(chain_len + 1);
    endfunction

endpackage

// File: rtl/cfg_shift_counter.sv
// cfg_shift_counter
// Down-counter that tracks the remaining shift (or verify) cycles of a load.
// Ports:
//   clk        in   clock, all state on posedge
//   reset      in   asynchronous active-high reset, clears count
//   load       in   load load_value (has priority over decrement)
//   load_value in   W-bit value to load
//   dec_en     in   decrement by one when count is non-zero
//   terminal   out  high while count == 1, i.e. the coming edge is the last one
module cfg_shift_counter
    import cfg_ctrl_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         dec_en,
    output logic         terminal
);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec_en && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign terminal = (count == W'(1));

endmodule

// File: rtl/cfg_chain_loader.sv
// cfg_chain_loader
// Serial loader for the PIRDSP configuration chain. Takes one parallel config
// word per valid/ready handshake and shifts it MSB-first into the chain,
// holding the DSP datapath frozen while the chain is in a transient state.
// Optional feature macro: CFG_READBACK_EN -- adds a VERIFY pass that
// recirculates the chain once and compares the tail against the loaded word.
// Ports:
//   clk                   in   clock, all state on posedge
//   reset                 in   asynchronous active-high reset
//   cfg_valid             in   config word offered
//   cfg_ready             out  loader idle; word accepted on valid & ready
//   cfg_data              in   CHAIN_LEN-bit word, bit CHAIN_LEN-1 is tail-most
//   cfg_done              out  one-cycle completion pulse
//   cfg_err               out  readback mismatch, valid with cfg_done
//   busy                  out  high from accept through the cfg_done cycle
//   dsp_hold              out  datapath freeze, identical to busy
//   configuration_input   out  serial bit into chain head
//   configuration_enable  out  chain shift enable
//   configuration_output  in   serial bit from chain tail
module cfg_chain_loader
    import cfg_ctrl_pkg::*;
#(
    parameter int CHAIN_LEN = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [CHAIN_LEN-1:0] cfg_data,
    output logic                 cfg_done,
    output logic                 cfg_err,
    output logic                 busy,
    output logic                 dsp_hold,
    output logic                 configuration_input,
    output logic                 configuration_enable,
    input  logic                 configuration_output
);

    localparam int              CNT_W      = cnt_width(CHAIN_LEN);
    localparam logic [CNT_W-1:0] LOAD_COUNT = CNT_W'(CHAIN_LEN);

    cfg_state_t           state;
    logic [CHAIN_LEN-1:0] shift_reg;
    logic                 input_q;
    logic                 accept;
    logic                 cnt_load;
    logic                 cnt_dec;
    logic                 cnt_last;

    assign accept = cfg_valid && cfg_ready;

`ifdef CFG_READBACK_EN
    // The counter is reused for the verify pass, so reload it on the last shift edge.
    assign cnt_load = accept || ((state == SHIFT) && cnt_last);
`else
    assign cnt_load = accept;
`endif
    assign cnt_dec = (state == SHIFT) || (state == VERIFY);

    cfg_shift_counter #(
        .W (CNT_W)
    ) u_counter (
        .clk        (clk),
        .reset      (reset),
        .load       (cnt_load),
        .load_value (LOAD_COUNT),
        .dec_en     (cnt_dec),
        .terminal   (cnt_last)
    );

    // The MSB goes out on the accept edge itself, so the shift register keeps
    // only the bits still to be sent; the chain captures one bit per edge with
    // no bubbles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state                <= IDLE;
            cfg_ready            <= 1'b1;
            cfg_done             <= 1'b0;
            busy                 <= 1'b0;
            configuration_enable <= 1'b0;
            input_q              <= 1'b0;
            shift_reg            <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        shift_reg            <= cfg_data << 1;
                        input_q              <= cfg_data[CHAIN_LEN-1];
                        configuration_enable <= 1'b1;
                        cfg_ready            <= 1'b0;
                        busy                 <= 1'b1;
                        state                <= SHIFT;
                    end
                end
                SHIFT: begin
                    input_q   <= shift_reg[CHAIN_LEN-1];
                    shift_reg <= shift_reg << 1;
                    if (cnt_last) begin
`ifdef CFG_READBACK_EN
                        state                <= VERIFY;
`else
                        configuration_enable <= 1'b0;
                        cfg_done             <= 1'b1;
                        state                <= DONE;
`endif
                    end
                end
`ifdef CFG_READBACK_EN
                VERIFY: begin
                    if (cnt_last) begin
                        configuration_enable <= 1'b0;
                        cfg_done             <= 1'b1;
                        state                <= DONE;
                    end
                end
`endif
                DONE: begin
                    cfg_done  <= 1'b0;
                    busy      <= 1'b0;
                    cfg_ready <= 1'b1;
                    input_q   <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign dsp_hold = busy;

`ifdef CFG_READBACK_EN
    logic [CHAIN_LEN-1:0] expect_reg;
    logic                 err_q;

    // Every verify edge rotates the chain by one, so the tail walks through
    // the loaded word MSB-first; any differing bit latches the error until
    // the next accepted word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            expect_reg <= '0;
            err_q      <= 1'b0;
        end else if (accept) begin
            expect_reg <= cfg_data;
            err_q      <= 1'b0;
        end else if (state == VERIFY) begin
            if (configuration_output != expect_reg[CHAIN_LEN-1]) begin
                err_q <= 1'b1;
            end
            expect_reg <= expect_reg << 1;
        end
    end

    assign cfg_err = err_q;
    // Recirculation must be same-cycle: a registered copy of the tail would
    // lag by one edge and the chain would not come back to its loaded value.
    assign configuration_input = (state == VERIFY) ? configuration_output : input_q;
`else
    logic unused_tail;

    assign unused_tail         = configuration_output;
    assign cfg_err             = 1'b0;
    assign configuration_input = input_q;
`endif

endmodule

// File: tb/tb_cfg_chain_loader.sv
// tb_cfg_chain_loader
// Bench for cfg_chain_loader: an 8-bit chain instance driven from a vector
// table plus hand sequences, and a 1-bit chain instance for the minimum
// length case. Both chains are modelled as simple shift registers.
// Honours CFG_READBACK_EN to match the DUT build.
`timescale 1ns/1ps
module tb_cfg_chain_loader;

    localparam int N = 8;
`ifdef CFG_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif
    // Enable cycles per load, and busy cycles seen at negedges after the
    // accept edge (the accept cycle itself makes up the remaining one).
    localparam int EXP_EN   = RB ? 2 * N : N;
    localparam int EXP_BUSY = RB ? 2 * N + 1 : N + 1;

    logic       clk;
    logic       reset;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [7:0] cfg_data;
    logic       cfg_done;
    logic       cfg_err;
    logic       busy;
    logic       dsp_hold;
    logic       cfg_in;
    logic       cfg_en;
    logic       cfg_out;

    logic       valid1;
    logic       ready1;
    logic [0:0] data1;
    logic       done1;
    logic       err1;
    logic       busy1;
    logic       hold1;
    logic       in1;
    logic       en1;
    logic       out1;

    int checks = 0;
    int errors = 0;

    logic [7:0] chain    = 8'h00;
    logic       chain1   = 1'b0;
    logic       flip_req = 1'b0;

    cfg_chain_loader #(.CHAIN_LEN(N)) dut (
        .clk                  (clk),
        .reset                (reset),
        .cfg_valid            (cfg_valid),
        .cfg_ready            (cfg_ready),
        .cfg_data             (cfg_data),
        .cfg_done             (cfg_done),
        .cfg_err              (cfg_err),
        .busy                 (busy),
        .dsp_hold             (dsp_hold),
        .configuration_input  (cfg_in),
        .configuration_enable (cfg_en),
        .configuration_output (cfg_out)
    );

    cfg_chain_loader #(.CHAIN_LEN(1)) dut1 (
        .clk                  (clk),
        .reset                (reset),
        .cfg_valid            (valid1),
        .cfg_ready            (ready1),
        .cfg_data             (data1),
        .cfg_done             (done1),
        .cfg_err              (err1),
        .busy                 (busy1),
        .dsp_hold             (hold1),
        .configuration_input  (in1),
        .configuration_enable (en1),
        .configuration_output (out1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Chain models: head is bit 0, tail is the MSB. flip_req corrupts bit 3
    // to emulate an upset inside the chain.
    always @(posedge clk) begin
        if (cfg_en) chain <= {chain[6:0], cfg_in} ^ (flip_req ? 8'h08 : 8'h00);
    end
    assign cfg_out = chain[7];

    always @(posedge clk) begin
        if (en1) chain1 <= in1;
    end
    assign out1 = chain1;

    typedef struct {
        logic [7:0] data;
        logic [7:0] exp_seq;
        logic [7:0] exp_chain;
    } vec_t;

    vec_t vecs[6];

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] data, input bit hold_valid);
        @(negedge clk);
        checkOutput("ready_before_accept", cfg_ready, 1);
        cfg_valid = 1'b1;
        cfg_data  = data;
        @(posedge clk);
        #1;
        cfg_valid = hold_valid;
        cfg_data  = ~data;
    endtask

    // Watches one load from just after the accept edge until the loader is
    // idle again, recording the first eight bits fed into the chain.
    task automatic runLoad(input int flip_at, output logic [7:0] seq,
                           output int en_cnt, output int done_cnt,
                           output int busy_cnt, output int hold_bad,
                           output bit timed_out);
        seq = 8'h00; en_cnt = 0; done_cnt = 0; busy_cnt = 0; hold_bad = 0;
        timed_out = 1'b1;
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(negedge clk);
            if (cfg_ready && !busy) begin
                timed_out = 1'b0;
                break;
            end
            if (cfg_en) begin
                if (en_cnt < 8) seq = {seq[6:0], cfg_in};
                en_cnt++;
            end
            if (cfg_done) done_cnt++;
            if (busy) busy_cnt++;
            if (busy !== dsp_hold) hold_bad++;
            flip_req = (cyc == flip_at);
        end
        flip_req = 1'b0;
    endtask

    task automatic loadAndCheck(input logic [7:0] data, input logic [7:0] exp_seq,
                                input logic [7:0] exp_chain, input logic exp_err,
                                input int flip_at, input bit hold_valid);
        logic [7:0] seq;
        int en_cnt, done_cnt, busy_cnt, hold_bad;
        bit timed_out;
        applyStimulus(data, hold_valid);
        runLoad(flip_at, seq, en_cnt, done_cnt, busy_cnt, hold_bad, timed_out);
        checkOutput("load_timeout", timed_out, 0);
        checkOutput("enable_cycles", en_cnt, EXP_EN);
        checkOutput("input_sequence", seq, exp_seq);
        checkOutput("done_pulses", done_cnt, 1);
        checkOutput("busy_cycles", busy_cnt, EXP_BUSY);
        checkOutput("hold_tracks_busy", hold_bad, 0);
        checkOutput("chain_contents", chain, exp_chain);
        checkOutput("cfg_err", cfg_err, exp_err);
        checkOutput("idle_enable", cfg_en, 0);
    endtask

    initial begin
        logic [7:0] seq;
        int en_cnt, done_cnt, busy_cnt, hold_bad;
        bit timed_out;
        int done_seen;
        int done_at;
        int en_cnt1;

        vecs[0] = '{data: 8'hA5, exp_seq: 8'b1010_0101, exp_chain: 8'hA5};
        vecs[1] = '{data: 8'h00, exp_seq: 8'b0000_0000, exp_chain: 8'h00};
        vecs[2] = '{data: 8'hFF, exp_seq: 8'b1111_1111, exp_chain: 8'hFF};
        vecs[3] = '{data: 8'h3C, exp_seq: 8'b0011_1100, exp_chain: 8'h3C};
        vecs[4] = '{data: 8'h81, exp_seq: 8'b1000_0001, exp_chain: 8'h81};
        vecs[5] = '{data: 8'h5A, exp_seq: 8'b0101_1010, exp_chain: 8'h5A};

        reset     = 1'b1;
        cfg_valid = 1'b0;
        cfg_data  = 8'h00;
        valid1    = 1'b0;
        data1     = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst_ready", cfg_ready, 1);
        checkOutput("rst_done", cfg_done, 0);
        checkOutput("rst_err", cfg_err, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_hold", dsp_hold, 0);
        checkOutput("rst_enable", cfg_en, 0);
        checkOutput("rst_input", cfg_in, 0);
        reset = 1'b0;

        // Table-driven loads, including an all-zero and all-one word.
        for (int i = 0; i < 6; i++) begin
            loadAndCheck(vecs[i].data, vecs[i].exp_seq, vecs[i].exp_chain, 1'b0, -1, 1'b0);
        end

        // Reset after four shifts of 8'hFF into a chain holding 8'h5A.
        applyStimulus(8'hFF, 1'b0);
        repeat (4) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("midrst_ready", cfg_ready, 1);
        checkOutput("midrst_done", cfg_done, 0);
        checkOutput("midrst_err", cfg_err, 0);
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_hold", dsp_hold, 0);
        checkOutput("midrst_enable", cfg_en, 0);
        checkOutput("midrst_input", cfg_in, 0);
        checkOutput("midrst_partial_chain", chain, 8'hAF);
        done_seen = 0;
        repeat (2) begin
            @(negedge clk);
            if (cfg_done) done_seen++;
        end
        reset = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (cfg_done) done_seen++;
        end
        checkOutput("aborted_no_done", done_seen, 0);
        loadAndCheck(8'h0F, 8'b0000_1111, 8'h0F, 1'b0, -1, 1'b0);

        // Valid held high: the word offered while busy is ignored and the
        // next load starts only after an idle cycle.
        loadAndCheck(8'h96, 8'b1001_0110, 8'h96, 1'b0, -1, 1'b1);
        checkOutput("b2b_gap_ready", cfg_ready, 1);
        checkOutput("b2b_gap_busy", busy, 0);
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        runLoad(-1, seq, en_cnt, done_cnt, busy_cnt, hold_bad, timed_out);
        checkOutput("b2b_timeout", timed_out, 0);
        checkOutput("b2b_sequence", seq, 8'b0110_1001);
        checkOutput("b2b_done_pulses", done_cnt, 1);
        checkOutput("b2b_chain", chain, 8'h69);

`ifdef CFG_READBACK_EN
        // Upset during SHIFT: bit 3 flipped at the fourth shift edge ends up
        // at the tail, so the restored chain is 8'h3C ^ 8'h80.
        loadAndCheck(8'h3C, 8'b0011_1100, 8'hBC, 1'b1, 3, 1'b0);
        loadAndCheck(8'h3C, 8'b0011_1100, 8'h3C, 1'b0, -1, 1'b0);
`endif

        // Single-bit chain.
        @(negedge clk);
        checkOutput("len1_ready", ready1, 1);
        valid1 = 1'b1;
        data1  = 1'b1;
        @(posedge clk);
        #1;
        valid1  = 1'b0;
        data1   = 1'b0;
        done_at = -1;
        en_cnt1 = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (ready1) break;
            if (en1) en_cnt1++;
            if (done1 && done_at < 0) done_at = c;
        end
        checkOutput("len1_done_cycle", done_at, RB ? 2 : 1);
        checkOutput("len1_enable_cycles", en_cnt1, RB ? 2 : 1);
        checkOutput("len1_chain", chain1, 1);
        checkOutput("len1_err", err1, 0);
        checkOutput("len1_idle", ready1, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
